frame_channel_arbiter: RTL and testbench

//  Shares the host read channel (tx0) and write channel (tx1) between the frame reader and the frame writer.

---
 rtl/frame_channel_arbiter_pkg.sv | 53 +++++
 rtl/frame_channel_arbiter_if.sv | 35 +++
 rtl/frame_rr_arb2.sv | 69 ++++++
 rtl/frame_channel_arbiter.sv | 106 ++++++++++
 tb/tb_frame_channel_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_channel_arbiter_pkg.sv
// Shared types for the frame channel arbiter: request frames, grant vectors,
// registered host tx beats, debug statistics and the requester identity.
package frame_channel_arbiter_pkg;

  localparam int unsigned HDR_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAT_W = 32;

  typedef enum logic {
    REQ_READER = 1'b0,
    REQ_WRITER = 1'b1
  } requester_e;

  // Read and write requests offered by one requester in a cycle.
  typedef struct packed {
    logic              rd_req;
    logic [HDR_W-1:0]  rd_hdr;
    logic              wr_req;
    logic [HDR_W-1:0]  wr_hdr;
    logic [DATA_W-1:0] wr_data;
  } frame_arb_t;

  // Per-channel grant vector; at most one field is set in any cycle.
  typedef struct packed {
    logic reader_grant;
    logic writer_grant;
  } channel_grant_arb_t;

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic             rdvalid;
  } tx_c0_t;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
    logic              wrvalid;
  } tx_c1_t;

  typedef struct packed {
    logic [STAT_W-1:0] rd_reader_cnt;
    logic [STAT_W-1:0] rd_writer_cnt;
    logic [STAT_W-1:0] wr_reader_cnt;
    logic [STAT_W-1:0] wr_writer_cnt;
    logic [STAT_W-1:0] c0_stall_cnt;
    logic [STAT_W-1:0] c1_stall_cnt;
  } t_AFU_DEBUG_RSP;

  function automatic requester_e other_req(input requester_e r);
    return (r == REQ_READER) ? REQ_WRITER : REQ_READER;
  endfunction

endpackage

// File: rtl/frame_channel_arbiter_if.sv
// Bus between the QA drivers/host (master) and the frame channel arbiter
// (slave). dbg_arb exists only when QA_ARB_STATS_EN is defined.
interface frame_channel_arbiter_if;
  import frame_channel_arbiter_pkg::*;

  logic               afu_en;
  frame_arb_t         rd_frame;
  frame_arb_t         wr_frame;
  channel_grant_arb_t rd_read_grant;
  channel_grant_arb_t wr_write_grant;
  logic               c0_almost_full;
  logic               c1_almost_full;
  tx_c0_t             tx0;
  tx_c1_t             tx1;
`ifdef QA_ARB_STATS_EN
  t_AFU_DEBUG_RSP     dbg_arb;
`endif

  modport master (
    output afu_en, rd_frame, wr_frame, c0_almost_full, c1_almost_full,
    input  rd_read_grant, wr_write_grant, tx0, tx1
`ifdef QA_ARB_STATS_EN
    , input dbg_arb
`endif
  );

  modport slave (
    input  afu_en, rd_frame, wr_frame, c0_almost_full, c1_almost_full,
    output rd_read_grant, wr_write_grant, tx0, tx1
`ifdef QA_ARB_STATS_EN
    , output dbg_arb
`endif
  );

endinterface

// File: rtl/frame_rr_arb2.sv
// Two-way round-robin arbiter with a burst cap. Grants are combinational;
// the pointer and burst counters advance on the clock edge of a grant.
module frame_rr_arb2
  import frame_channel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BURST_W   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_reader,
  input  logic req_writer,
  output logic grant_reader,
  output logic grant_writer
);

  localparam logic [BURST_W-1:0] CAP = BURST_W'(MAX_BURST);

  requester_e         ptr, ptr_nxt, winner;
  logic [BURST_W-1:0] cnt_reader, cnt_writer;
  logic [BURST_W-1:0] cnt_reader_nxt, cnt_writer_nxt;
  logic [BURST_W-1:0] fav_cnt;
  logic               grant_any, both;

  // Pointer and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= REQ_READER;
      cnt_reader <= '0;
      cnt_writer <= '0;
    end else begin
      ptr        <= ptr_nxt;
      cnt_reader <= cnt_reader_nxt;
      cnt_writer <= cnt_writer_nxt;
    end
  end

  // Winner selection and next pointer/counter values; state holds when idle.
  always_comb begin
    winner         = REQ_READER;
    grant_any      = 1'b0;
    ptr_nxt        = ptr;
    cnt_reader_nxt = cnt_reader;
    cnt_writer_nxt = cnt_writer;
    both           = en && req_reader && req_writer;
    fav_cnt        = (ptr == REQ_READER) ? cnt_reader : cnt_writer;
    if (en && (req_reader || req_writer)) begin
      grant_any = 1'b1;
      if (both) begin
        winner = (fav_cnt == CAP) ? other_req(ptr) : ptr;
      end else begin
        winner = req_reader ? REQ_READER : REQ_WRITER;
      end
      ptr_nxt = other_req(winner);
      if (winner == REQ_READER) begin
        cnt_reader_nxt = !both ? '0 : (cnt_reader == CAP) ? cnt_reader : cnt_reader + 1'b1;
        cnt_writer_nxt = '0;
      end else begin
        cnt_writer_nxt = !both ? '0 : (cnt_writer == CAP) ? cnt_writer : cnt_writer + 1'b1;
        cnt_reader_nxt = '0;
      end
    end
  end

  assign grant_reader = grant_any && (winner == REQ_READER);
  assign grant_writer = grant_any && (winner == REQ_WRITER);

endmodule

// File: rtl/frame_channel_arbiter.sv
// Shares host tx0 (read) and tx1 (write) between the frame reader and frame
// writer: one frame_rr_arb2 per channel, grant routing, registered tx beats.
// Optional statistics on dbg_arb when QA_ARB_STATS_EN is defined.
module frame_channel_arbiter
  import frame_channel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BURST_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_channel_arbiter_if.slave bus
);

  logic   rd_en, wr_en;
  logic   rd_g_reader, rd_g_writer, wr_g_reader, wr_g_writer;
  tx_c0_t tx0_q;
  tx_c1_t tx1_q;

  // Grants are suppressed while reset is high so nothing issued in that
  // cycle can be mistaken for a live grant by the requesters.
  assign rd_en = bus.afu_en && !bus.c0_almost_full && !reset;
  assign wr_en = bus.afu_en && !bus.c1_almost_full && !reset;

  frame_rr_arb2 #(.MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) u_rd_arb (
    .clk          (clk),
    .reset        (reset),
    .en           (rd_en),
    .req_reader   (bus.rd_frame.rd_req),
    .req_writer   (bus.wr_frame.rd_req),
    .grant_reader (rd_g_reader),
    .grant_writer (rd_g_writer)
  );

  frame_rr_arb2 #(.MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) u_wr_arb (
    .clk          (clk),
    .reset        (reset),
    .en           (wr_en),
    .req_reader   (bus.rd_frame.wr_req),
    .req_writer   (bus.wr_frame.wr_req),
    .grant_reader (wr_g_reader),
    .grant_writer (wr_g_writer)
  );

  assign bus.rd_read_grant.reader_grant  = rd_g_reader;
  assign bus.rd_read_grant.writer_grant  = rd_g_writer;
  assign bus.wr_write_grant.reader_grant = wr_g_reader;
  assign bus.wr_write_grant.writer_grant = wr_g_writer;

  // tx0: register the granted read header; header holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx0_q <= '0;
    end else begin
      tx0_q.rdvalid <= rd_g_reader || rd_g_writer;
      if (rd_g_reader)      tx0_q.hdr <= bus.rd_frame.rd_hdr;
      else if (rd_g_writer) tx0_q.hdr <= bus.wr_frame.rd_hdr;
    end
  end

  // tx1: register the granted write header and data; both hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx1_q <= '0;
    end else begin
      tx1_q.wrvalid <= wr_g_reader || wr_g_writer;
      if (wr_g_reader) begin
        tx1_q.hdr  <= bus.rd_frame.wr_hdr;
        tx1_q.data <= bus.rd_frame.wr_data;
      end else if (wr_g_writer) begin
        tx1_q.hdr  <= bus.wr_frame.wr_hdr;
        tx1_q.data <= bus.wr_frame.wr_data;
      end
    end
  end

  assign bus.tx0 = tx0_q;
  assign bus.tx1 = tx1_q;

`ifdef QA_ARB_STATS_EN
  t_AFU_DEBUG_RSP dbg_q;
  logic           c0_stall, c1_stall;

  assign c0_stall = bus.afu_en && bus.c0_almost_full &&
                    (bus.rd_frame.rd_req || bus.wr_frame.rd_req);
  assign c1_stall = bus.afu_en && bus.c1_almost_full &&
                    (bus.rd_frame.wr_req || bus.wr_frame.wr_req);

  // Wrapping grant and almost-full stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_q <= '0;
    end else begin
      if (rd_g_reader) dbg_q.rd_reader_cnt <= dbg_q.rd_reader_cnt + 1'b1;
      if (rd_g_writer) dbg_q.rd_writer_cnt <= dbg_q.rd_writer_cnt + 1'b1;
      if (wr_g_reader) dbg_q.wr_reader_cnt <= dbg_q.wr_reader_cnt + 1'b1;
      if (wr_g_writer) dbg_q.wr_writer_cnt <= dbg_q.wr_writer_cnt + 1'b1;
      if (c0_stall)    dbg_q.c0_stall_cnt  <= dbg_q.c0_stall_cnt + 1'b1;
      if (c1_stall)    dbg_q.c1_stall_cnt  <= dbg_q.c1_stall_cnt + 1'b1;
    end
  end

  assign bus.dbg_arb = dbg_q;
`endif

endmodule

// File: tb/tb_frame_channel_arbiter.sv
// Self-checking bench for frame_channel_arbiter against a behavioural model
// of the round-robin/burst-cap rules and one-cycle tx latency.
module tb_frame_channel_arbiter;
  import frame_channel_arbiter_pkg::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  frame_channel_arbiter_if ifc();

  frame_channel_arbiter #(.MAX_BURST(MAXB), .BURST_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Model state: favourite per channel (0 reader, 1 writer), consecutive
  // contested wins per channel/requester, expected registered tx beats.
  int     fav[2];
  int     streak[2][2];
  tx_c0_t exp_tx0;
  tx_c1_t exp_tx1;
  longint st_cnt[6];

  task automatic model_reset();
    fav[0] = 0; fav[1] = 0;
    streak[0][0] = 0; streak[0][1] = 0; streak[1][0] = 0; streak[1][1] = 0;
    exp_tx0 = '0;
    exp_tx1 = '0;
    for (int i = 0; i < 6; i++) st_cnt[i] = 0;
  endtask

  task automatic arb_model(input int ch, input bit en, input bit q0, input bit q1,
                           output bit g0, output bit g1);
    int w;
    bit contested;
    g0 = 0; g1 = 0;
    if (!en || !(q0 || q1)) return;
    contested = q0 && q1;
    if (contested) begin
      w = fav[ch];
      if (streak[ch][w] == MAXB) w = 1 - w;
    end else begin
      w = q0 ? 0 : 1;
    end
    fav[ch] = 1 - w;
    streak[ch][w] = contested ? ((streak[ch][w] < MAXB) ? streak[ch][w] + 1 : MAXB) : 0;
    streak[ch][1 - w] = 0;
    if (w == 0) g0 = 1; else g1 = 1;
  endtask

  // Predict this cycle's grants from the currently driven inputs and advance
  // the model across the coming clock edge.
  task automatic predict(output channel_grant_arb_t erg, output channel_grant_arb_t ewg);
    bit g0, g1, h0, h1;
    arb_model(0, ifc.afu_en && !ifc.c0_almost_full, ifc.rd_frame.rd_req, ifc.wr_frame.rd_req, g0, g1);
    arb_model(1, ifc.afu_en && !ifc.c1_almost_full, ifc.rd_frame.wr_req, ifc.wr_frame.wr_req, h0, h1);
    erg.reader_grant = g0; erg.writer_grant = g1;
    ewg.reader_grant = h0; ewg.writer_grant = h1;
    exp_tx0.rdvalid = g0 | g1;
    if (g0) exp_tx0.hdr = ifc.rd_frame.rd_hdr;
    if (g1) exp_tx0.hdr = ifc.wr_frame.rd_hdr;
    exp_tx1.wrvalid = h0 | h1;
    if (h0) begin exp_tx1.hdr = ifc.rd_frame.wr_hdr; exp_tx1.data = ifc.rd_frame.wr_data; end
    if (h1) begin exp_tx1.hdr = ifc.wr_frame.wr_hdr; exp_tx1.data = ifc.wr_frame.wr_data; end
    if (g0) st_cnt[0]++;
    if (g1) st_cnt[1]++;
    if (h0) st_cnt[2]++;
    if (h1) st_cnt[3]++;
    if (ifc.afu_en && ifc.c0_almost_full && (ifc.rd_frame.rd_req || ifc.wr_frame.rd_req)) st_cnt[4]++;
    if (ifc.afu_en && ifc.c1_almost_full && (ifc.rd_frame.wr_req || ifc.wr_frame.wr_req)) st_cnt[5]++;
  endtask

  task automatic drive(input bit en, input bit rr, input bit rw, input bit wr, input bit ww,
                       input bit a0, input bit a1);
    ifc.afu_en           = en;
    ifc.c0_almost_full   = a0;
    ifc.c1_almost_full   = a1;
    ifc.rd_frame.rd_req  = rr;
    ifc.rd_frame.rd_hdr  = HDR_W'($urandom);
    ifc.rd_frame.wr_req  = rw;
    ifc.rd_frame.wr_hdr  = HDR_W'($urandom);
    ifc.rd_frame.wr_data = $urandom;
    ifc.wr_frame.rd_req  = wr;
    ifc.wr_frame.rd_hdr  = HDR_W'($urandom);
    ifc.wr_frame.wr_req  = ww;
    ifc.wr_frame.wr_hdr  = HDR_W'($urandom);
    ifc.wr_frame.wr_data = $urandom;
  endtask

  task automatic test_reset();
    channel_grant_arb_t erg, ewg;
    reset = 1'b1;
    drive(1, 1, 1, 1, 1, 0, 0);
    model_reset();
    #1;
    total++;
    if ({ifc.rd_read_grant, ifc.wr_write_grant} !== 4'b0000) begin
      bad++; $display("FAIL reset_grants got=%b exp=0000", {ifc.rd_read_grant, ifc.wr_write_grant});
    end
    @(negedge clk);
    total++;
    if ({ifc.tx0, ifc.tx1} !== '0) begin
      bad++; $display("FAIL reset_tx got=%h/%h exp=0", ifc.tx0, ifc.tx1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 predict(erg, ewg);
  endtask

  task automatic test_reader_only();
    channel_grant_arb_t erg, ewg;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
        bad++; $display("FAIL reader_only_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
      end
      if (i >= 1) begin
        total++;
        if (ifc.tx0.rdvalid !== 1'b1) begin
          bad++; $display("FAIL reader_only_rdvalid cycle=%0d got=%b exp=1", i, ifc.tx0.rdvalid);
        end
      end
      drive(1, 1, 0, 0, 0, 0, 0);
      #1 predict(erg, ewg);
      total++;
      if ({ifc.rd_read_grant, ifc.wr_write_grant} !== {erg, ewg}) begin
        bad++; $display("FAIL reader_only_grant got=%b exp=%b", {ifc.rd_read_grant, ifc.wr_write_grant}, {erg, ewg});
      end
    end
  endtask

  task automatic test_alternation();
    channel_grant_arb_t erg, ewg;
    logic prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
        bad++; $display("FAIL alternation_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
      end
      drive(1, 1, 0, 1, 0, 0, 0);
      #1 predict(erg, ewg);
      total++;
      if ({ifc.rd_read_grant, ifc.wr_write_grant} !== {erg, ewg}) begin
        bad++; $display("FAIL alternation_grant got=%b exp=%b", {ifc.rd_read_grant, ifc.wr_write_grant}, {erg, ewg});
      end
      if (i > 0) begin
        total++;
        if (ifc.rd_read_grant.reader_grant !== ~prev) begin
          bad++; $display("FAIL alternation_order cycle=%0d got=%b exp=%b", i, ifc.rd_read_grant.reader_grant, ~prev);
        end
      end
      prev = ifc.rd_read_grant.reader_grant;
    end
  endtask

  task automatic test_almost_full();
    channel_grant_arb_t erg, ewg;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
        bad++; $display("FAIL almost_full_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
      end
      if (i >= 2 && i <= 5) begin
        total++;
        if (ifc.tx0.rdvalid !== 1'b0) begin
          bad++; $display("FAIL almost_full_rdvalid cycle=%0d got=%b exp=0", i, ifc.tx0.rdvalid);
        end
      end
      drive(1, 1, 1, 1, 1, (i < 5), 0);
      #1 predict(erg, ewg);
      total++;
      if ({ifc.rd_read_grant, ifc.wr_write_grant} !== {erg, ewg}) begin
        bad++; $display("FAIL almost_full_grant got=%b exp=%b", {ifc.rd_read_grant, ifc.wr_write_grant}, {erg, ewg});
      end
      if (i < 5) begin
        total++;
        if (ifc.rd_read_grant !== 2'b00 || ifc.tx1.wrvalid === 1'bx) begin
          bad++; $display("FAIL almost_full_blocked got=%b exp=00", ifc.rd_read_grant);
        end
      end
    end
  endtask

  task automatic test_writer_burst();
    channel_grant_arb_t erg, ewg;
    int run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
        bad++; $display("FAIL writer_burst_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
      end
      drive(1, 0, (i == 5), 0, 1, 0, 0);
      #1 predict(erg, ewg);
      total++;
      if ({ifc.rd_read_grant, ifc.wr_write_grant} !== {erg, ewg}) begin
        bad++; $display("FAIL writer_burst_grant got=%b exp=%b", {ifc.rd_read_grant, ifc.wr_write_grant}, {erg, ewg});
      end
      if (i == 5) begin
        total++;
        if (ifc.wr_write_grant.reader_grant !== 1'b1) begin
          bad++; $display("FAIL writer_burst_reader_wait got=%b exp=1", ifc.wr_write_grant.reader_grant);
        end
      end
      run = (ifc.wr_write_grant.writer_grant && ifc.rd_frame.wr_req) ? run + 1 : 0;
      total++;
      if (run > MAXB) begin
        bad++; $display("FAIL writer_burst_cap run=%0d max=%0d", run, MAXB);
      end
    end
  endtask

  task automatic test_random();
    channel_grant_arb_t erg, ewg;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      total++;
      if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
        bad++; $display("FAIL random_tx cycle=%0d got=%h/%h exp=%h/%h", i, ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
      end
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      #1 predict(erg, ewg);
      total++;
      if ({ifc.rd_read_grant, ifc.wr_write_grant} !== {erg, ewg}) begin
        bad++; $display("FAIL random_grant cycle=%0d got=%b exp=%b", i, {ifc.rd_read_grant, ifc.wr_write_grant}, {erg, ewg});
      end
    end
  endtask

  task automatic test_async_reset();
    channel_grant_arb_t erg, ewg;
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 0, 0);
    #1 predict(erg, ewg);
    @(negedge clk);
    total++;
    if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1} || ifc.tx1.wrvalid !== 1'b1) begin
      bad++; $display("FAIL async_pre_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (ifc.tx1.wrvalid !== 1'b0 || ifc.tx0 !== '0) begin
      bad++; $display("FAIL async_reset_tx got=%h/%h exp=0", ifc.tx0, ifc.tx1);
    end
    total++;
    if ({ifc.rd_read_grant, ifc.wr_write_grant} !== 4'b0000) begin
      bad++; $display("FAIL async_reset_grant got=%b exp=0000", {ifc.rd_read_grant, ifc.wr_write_grant});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 1, 1, 1, 0, 0);
    #1 predict(erg, ewg);
    total++;
    if (ifc.rd_read_grant !== 2'b10 || ifc.wr_write_grant !== 2'b10) begin
      bad++; $display("FAIL async_post_favour got=%b/%b exp=10/10", ifc.rd_read_grant, ifc.wr_write_grant);
    end
    @(negedge clk);
    total++;
    if ({ifc.tx0, ifc.tx1} !== {exp_tx0, exp_tx1}) begin
      bad++; $display("FAIL async_post_tx got=%h/%h exp=%h/%h", ifc.tx0, ifc.tx1, exp_tx0, exp_tx1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 predict(erg, ewg);
  endtask

`ifdef QA_ARB_STATS_EN
  task automatic test_stats();
    channel_grant_arb_t erg, ewg;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(1, (i < 13), 0, 0, 0, (i >= 10 && i < 13), 0);
      #1 predict(erg, ewg);
      @(negedge clk);
    end
    total++;
    if (ifc.dbg_arb.rd_reader_cnt !== 32'd10) begin
      bad++; $display("FAIL stats_reader_reads got=%0d exp=10", ifc.dbg_arb.rd_reader_cnt);
    end
    total++;
    if (ifc.dbg_arb.c0_stall_cnt !== 32'd3) begin
      bad++; $display("FAIL stats_c0_stall got=%0d exp=3", ifc.dbg_arb.c0_stall_cnt);
    end
    total++;
    if (ifc.dbg_arb.rd_writer_cnt !== 32'(st_cnt[1]) || ifc.dbg_arb.wr_reader_cnt !== 32'(st_cnt[2]) ||
        ifc.dbg_arb.wr_writer_cnt !== 32'(st_cnt[3]) || ifc.dbg_arb.c1_stall_cnt !== 32'(st_cnt[5])) begin
      bad++; $display("FAIL stats_other got=%h exp=0", ifc.dbg_arb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reader_only();
    test_alternation();
    test_almost_full();
    test_writer_burst();
    test_random();
    test_async_reset();
`ifdef QA_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
